// File: rtl/weight_stream_rx.sv
// rtl/weight_stream_rx.sv - ping-pong kernel assembler between the weight FIFO and the conv MAC array
module weight_stream_rx #(
  parameter int COEFF_WIDTH = 16,
  parameter int KERN_SIZE   = 9
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic [COEFF_WIDTH-1:0]          input_V_dout,
  input  logic                            input_V_empty_n,
  output logic                            input_V_read,
  output logic [KERN_SIZE*COEFF_WIDTH-1:0] kern_data,
  output logic                            kern_valid,
  input  logic                            kern_ready,
  output logic [15:0]                     kern_count
);

  localparam int IDX_W = $clog2(KERN_SIZE);

  logic [COEFF_WIDTH-1:0] bank_q [2][KERN_SIZE];
  logic [1:0]             full_q, full_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [15:0]            kern_count_q, kern_count_d;
  logic                   xfer;
  logic                   last_word;

  // Pop only into a bank that is not holding a complete kernel; never depends on kern_ready.
  assign input_V_read = ap_rst_n & input_V_empty_n & ~full_q[wr_bank_q];
  assign kern_valid   = full_q[rd_bank_q];
  assign xfer         = kern_valid & kern_ready;
  assign last_word    = (wr_idx_q == IDX_W'(KERN_SIZE - 1));
  assign kern_count   = kern_count_q;

  always_comb begin
    kern_data = '0;
    for (int i = 0; i < KERN_SIZE; i++) begin
      kern_data[i*COEFF_WIDTH +: COEFF_WIDTH] = bank_q[rd_bank_q][i];
    end
  end

  // Fill completion and transfer always target different banks, so both updates can apply.
  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;
    kern_count_d = kern_count_q;
    if (input_V_read) begin
      if (last_word) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (xfer) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      kern_count_d      = kern_count_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      kern_count_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < KERN_SIZE; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      kern_count_q <= kern_count_d;
      if (input_V_read) begin
        bank_q[wr_bank_q][wr_idx_q] <= input_V_dout;
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_rx.sv
// tb/tb_weight_stream_rx.sv - directed self-checking bench for weight_stream_rx
module tb_weight_stream_rx;

  localparam int CW = 16;
  localparam int KS = 9;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [CW-1:0]    input_V_dout;
  logic             input_V_empty_n;
  logic             input_V_read;
  logic [KS*CW-1:0] kern_data;
  logic             kern_valid;
  logic             kern_ready;
  logic [15:0]      kern_count;

  weight_stream_rx #(.COEFF_WIDTH(CW), .KERN_SIZE(KS)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .input_V_dout   (input_V_dout),
    .input_V_empty_n(input_V_empty_n),
    .input_V_read   (input_V_read),
    .kern_data      (kern_data),
    .kern_valid     (kern_valid),
    .kern_ready     (kern_ready),
    .kern_count     (kern_count)
  );

  always #5 ap_clk = ~ap_clk;

  logic [CW-1:0] fifo[$];
  logic [CW-1:0] exp_k[KS];
  logic          gate;
  logic          bursty;
  logic          popped;
  int            pops;
  int            n_checks;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_kern(input string tag);
    for (int i = 0; i < KS; i++) begin
      logic [CW-1:0] c;
      c = kern_data[i*CW +: CW];
      check($sformatf("%s[%0d]", tag, i), 32'(c), 32'(exp_k[i]));
    end
  endtask

  task automatic drive();
    input_V_empty_n = (fifo.size() > 0) && gate;
    input_V_dout    = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  // One clock: sample the pop strobe mid-cycle, advance the FIFO model after the edge.
  task automatic tick();
    @(negedge ap_clk);
    popped = input_V_read;
    @(posedge ap_clk);
    #1;
    if (popped) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (bursty) gate = ~gate;
    drive();
  endtask

  task automatic push_seq(input logic [CW-1:0] first, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(first + CW'(i));
  endtask

  task automatic set_exp_seq(input logic [CW-1:0] first);
    for (int i = 0; i < KS; i++) exp_k[i] = first + CW'(i);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pops = 0;
    gate = 1'b1; bursty = 1'b0; kern_ready = 1'b0;
    ap_rst_n = 1'b0;
    push_seq(16'd1, 9);
    drive();
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_valid", 32'(kern_valid), 32'd0);
    check("rst_count", 32'(kern_count), 32'd0);
    check("rst_data_zero", 32'(kern_data == '0), 32'd1);
    check("rst_read", 32'(input_V_read), 32'd0);

    // Continuous fill with the consumer always ready
    kern_ready = 1'b1;
    ap_rst_n = 1'b1;
    drive();
    repeat (8) tick();
    check("fill_valid_early", 32'(kern_valid), 32'd0);
    tick();
    check("fill_pops", 32'(pops), 32'd9);
    check("fill_valid", 32'(kern_valid), 32'd1);
    check("fill_count_before", 32'(kern_count), 32'd0);
    set_exp_seq(16'd1);
    check_kern("fill_data");
    tick();
    check("fill_valid_one_cycle", 32'(kern_valid), 32'd0);
    check("fill_count", 32'(kern_count), 32'd1);

    // Backpressure: both banks fill, then drain one transfer at a time
    kern_ready = 1'b0;
    pops = 0;
    push_seq(16'd1, 27);
    drive();
    repeat (18) tick();
    check("bp_pops18", 32'(pops), 32'd18);
    check("bp_read_blocked", 32'(input_V_read), 32'd0);
    check("bp_empty_n", 32'(input_V_empty_n), 32'd1);
    repeat (4) tick();
    check("bp_pops_held", 32'(pops), 32'd18);
    check("bp_valid", 32'(kern_valid), 32'd1);
    set_exp_seq(16'd1);
    check_kern("bp_k0");
    kern_ready = 1'b1;
    tick();
    check("bp_no_pop_on_xfer", 32'(popped), 32'd0);
    check("bp_count_a", 32'(kern_count), 32'd2);
    check("bp_valid_nogap", 32'(kern_valid), 32'd1);
    set_exp_seq(16'd10);
    check_kern("bp_k1");
    check("bp_read_resumes", 32'(input_V_read), 32'd1);
    kern_ready = 1'b0;
    tick();
    check("bp_pop_after_bubble", 32'(popped), 32'd1);
    repeat (8) tick();
    check("bp_pops27", 32'(pops), 32'd27);
    check_kern("bp_k1_stable");
    kern_ready = 1'b1;
    tick();
    check("bp_count_b", 32'(kern_count), 32'd3);
    check("bp_valid_b", 32'(kern_valid), 32'd1);
    set_exp_seq(16'd19);
    check_kern("bp_k2");
    tick();
    check("bp_count_c", 32'(kern_count), 32'd4);
    check("bp_valid_c", 32'(kern_valid), 32'd0);

    // Bursty source
    kern_ready = 1'b0;
    pops = 0;
    bursty = 1'b1;
    push_seq(16'h0001, 9);
    drive();
    begin
      int budget;
      budget = 0;
      while (pops < 9 && budget < 40) begin
        tick();
        budget++;
        if (pops < 9 && kern_valid) check("burst_valid_early", 32'(kern_valid), 32'd0);
      end
      check("burst_timeout", 32'(budget < 40), 32'd1);
    end
    bursty = 1'b0; gate = 1'b1;
    drive();
    check("burst_valid", 32'(kern_valid), 32'd1);
    check("burst_fifo_drained", 32'(fifo.size()), 32'd0);
    set_exp_seq(16'h0001);
    check_kern("burst_data");
    kern_ready = 1'b1;
    tick();
    kern_ready = 1'b0;
    check("burst_count", 32'(kern_count), 32'd5);

    // Reset in the middle of a fill
    push_seq(16'h0050, 9);
    drive();
    repeat (4) tick();
    ap_rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(kern_valid), 32'd0);
    check("mrst_data_zero", 32'(kern_data == '0), 32'd1);
    check("mrst_read", 32'(input_V_read), 32'd0);
    check("mrst_count", 32'(kern_count), 32'd0);
    tick();
    check("mrst_read_held", 32'(input_V_read), 32'd0);
    fifo.delete();
    push_seq(16'h00A0, 9);
    ap_rst_n = 1'b1;
    drive();
    repeat (9) tick();
    check("mrst_valid_after", 32'(kern_valid), 32'd1);
    set_exp_seq(16'h00A0);
    check_kern("mrst_data");
    kern_ready = 1'b1;
    tick();
    kern_ready = 1'b0;
    check("mrst_count_after", 32'(kern_count), 32'd1);

    // Last word of one bank lands in the same cycle the other bank transfers
    pops = 0;
    push_seq(16'h00B0, 9);
    push_seq(16'h00C0, 9);
    drive();
    repeat (17) tick();
    check("ovl_pops17", 32'(pops), 32'd17);
    set_exp_seq(16'h00B0);
    check_kern("ovl_k0");
    kern_ready = 1'b1;
    tick();
    check("ovl_pop18", 32'(popped), 32'd1);
    check("ovl_valid", 32'(kern_valid), 32'd1);
    check("ovl_count", 32'(kern_count), 32'd2);
    set_exp_seq(16'h00C0);
    check_kern("ovl_k1");
    tick();
    kern_ready = 1'b0;
    check("ovl_count_end", 32'(kern_count), 32'd3);

    // Bit-exact coefficients
    exp_k = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0001,
              16'hFFFE, 16'h5555, 16'hAAAA, 16'h8001};
    for (int i = 0; i < KS; i++) fifo.push_back(exp_k[i]);
    drive();
    repeat (9) tick();
    check("bits_valid", 32'(kern_valid), 32'd1);
    check_kern("bits_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_stream_rx.md
# weight_stream_rx

Receiving end of the coefficient stream produced by the per-layer weight ROM streamers. It pops coefficients from an ap_fifo-style stream and assembles them into a full kernel in one of two ping-pong banks. It then presents the complete kernel in parallel to the convolution MAC array through a valid/ready handshake. The block sits between the weight FIFO and the conv datapath, so one bank can fill while the other is being consumed.

## Interface
- COEFF_WIDTH, default 16: width of one coefficient (matches `coeff_width`).
- KERN_SIZE, default 9: coefficients per kernel; legal range 2..256.
- ap_clk  in  1  clock; all state changes on its rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- input_V_dout  in  COEFF_WIDTH  head-of-FIFO coefficient; valid while input_V_empty_n=1.
- input_V_empty_n  in  1  FIFO holds at least one word.
- input_V_read  out  1  pop strobe; the word on input_V_dout is consumed in the same cycle.
- kern_data  out  KERN_SIZE*COEFF_WIDTH  presented kernel; coefficient i (stream order) at bits [i*COEFF_WIDTH +: COEFF_WIDTH].
- kern_valid  out  1  kern_data holds a complete kernel.
- kern_ready  in  1  consumer accepts the kernel; a transfer occurs when kern_valid & kern_ready.
- kern_count  out  16  number of kernels handed off; wraps modulo 2^16.

## Operation
- State:
  - two banks of KERN_SIZE coefficient registers
  - full[1:0] flags
  - wr_bank and rd_bank pointers (1 bit each)
  - wr_idx counter, 0..KERN_SIZE-1
- Read rule (combinational):
  - input_V_read = ap_rst_n & input_V_empty_n & ~full[wr_bank].
  - No other term is allowed; in particular, no combinational path from kern_ready.
- On each cycle with input_V_read=1:
  - bank[wr_bank][wr_idx] <= input_V_dout.
  - If wr_idx = KERN_SIZE-1: wr_idx <= 0, full[wr_bank] <= 1, wr_bank toggles.
  - Otherwise: wr_idx increments.
- Output side:
  - kern_valid = full[rd_bank].
  - kern_data = bank[rd_bank], a registered path with no muxing beyond the rd_bank select.
- On a transfer: full[rd_bank] <= 0, rd_bank toggles, kern_count increments.
- Simultaneous events:
  - Fill completion on one bank and a transfer on the other in the same cycle: both take effect.
  - Fill completion and a transfer on the same bank cannot occur, because a full bank is never being written.
- Backpressure:
  - With both banks full, input_V_read=0 regardless of input_V_empty_n.
  - A transfer frees a bank. Reading resumes the following cycle: one-cycle bubble, because the flag is registered.
- Data is stored bit-exact; no sign handling or arithmetic is applied.
- Reset, asynchronous, also applies mid-operation:
  - full=0, wr_bank=0, rd_bank=0, wr_idx=0.
  - All bank registers are cleared to 0, so kern_data=0.
  - kern_valid=0, kern_count=0.
  - input_V_read is forced 0 while ap_rst_n=0.
  - A partially filled kernel is discarded. Words already popped are lost, not replayed.

## Timing
- Fill latency: first word popped at cycle t and the rest popped in consecutive cycles → last word at t+KERN_SIZE-1 → kern_valid=1 from t+KERN_SIZE.
- Sustained throughput: one kernel per KERN_SIZE cycles when the FIFO never empties and the consumer accepts within KERN_SIZE cycles.
- kern_valid stays high and kern_data stays stable until the transfer (AXI-style; no withdrawal).
- After a transfer, kern_valid in the next cycle reflects the other bank's flag. If that bank is already full, kern_valid stays high with new data and shows no gap.
- Gaps on input_V_empty_n only stall wr_idx; they never corrupt bank contents.

## Test plan
- Continuous fill, KERN_SIZE=9:
  - Stimulus: FIFO holds 1..9, kern_ready=1.
  - Response: input_V_read high for 9 cycles. kern_valid high for exactly 1 cycle at cycle 10, with coefficient i = i+1. kern_count=1.
- Backpressure:
  - Stimulus: 27 words 1..27, kern_ready=0.
  - Response: exactly 18 pops, then input_V_read=0 while empty_n=1.
  - Next stimulus: raise kern_ready.
  - Response: kernels {1..9}, {10..18}, {19..27} in order. Reads resume exactly one cycle after the first transfer. kern_count=3.
- Bursty source:
  - Stimulus: input_V_empty_n toggling every cycle, 9 words 0x0001..0x0009.
  - Response: kern_valid rises after the 9th pop. Data is correct and no word is duplicated or skipped.
- Reset mid-fill:
  - Stimulus: assert ap_rst_n=0 after 4 pops, release, then stream 9 new words 0xA0..0xA8.
  - Response: during reset, kern_valid=0, kern_data=0, input_V_read=0. After release, the first kernel is exactly 0xA0..0xA8.
- Overlapped fill and transfer:
  - Stimulus: bank0 is presented with kern_ready held low. The 9th word of bank1 is popped in the same cycle kern_ready rises.
  - Response: next cycle kern_valid=1 with bank1 data. kern_count increments by exactly 1.
- Bit-exact data:
  - Stimulus: coefficients 0xFFFF, 0x8000, 0x7FFF, …
  - Response: the same values appear unmodified in kern_data.
